// File: rtl/divider_pkg.sv
// Shared types and sizes for the sequential restoring divider.
// State encoding, default operand width and iteration counter width.
package divider_pkg;

  localparam int DIV_W = 8;
  localparam int CNT_W = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_t;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational trial subtractor for one restoring-division step.
// Ports: a, b (W bits) in; diff = a - b, neg = sign bit of diff.
module div_trial_sub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         neg
);

  assign diff = a - b;
  assign neg  = diff[W-1];

endmodule

// File: rtl/seq_divider8.sv
// Sequential restoring divider, one quotient bit per clock.
// Ports: Clk, Reset_n, Start, Dividend, Divisor in;
//   Busy, Done, Quotient, Remainder, DivZero out.
// Macro SEQ_DIVIDER8_SIGNED_EN: two's complement operands, FIXUP state.
module seq_divider8
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t state, state_nx;

  logic [WIDTH:0]   a, a_sh, a_nx, t;
  logic             t_neg;
  logic [WIDTH-1:0] q, q_nx, m;
  logic [WIDTH-1:0] quo, rem;
  logic [CW-1:0]    count;
  logic             last, dz, accept;
  logic [WIDTH-1:0] dd_mag, dv_mag;

`ifdef SEQ_DIVIDER8_SIGNED_EN
  localparam state_t POST = FIXUP;
  logic neg_q, neg_r;
  assign dd_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
  assign dv_mag = Divisor[WIDTH-1] ? -Divisor : Divisor;
`else
  localparam state_t POST = DONE;
  assign dd_mag = Dividend;
  assign dv_mag = Divisor;
`endif

  // a stays below m after every step, so its top bit is always
  // zero and can be dropped by the shift.
  assign a_sh = {a[WIDTH-1:0], q[WIDTH-1]};

  div_trial_sub #(.W(WIDTH + 1)) u_sub (
    .a    (a_sh),
    .b    ({1'b0, m}),
    .diff (t),
    .neg  (t_neg)
  );

  assign a_nx   = t_neg ? a_sh : t;
  assign q_nx   = {q[WIDTH-2:0], ~t_neg};
  assign last   = (count == CW'(WIDTH - 1));
  assign accept = (state == IDLE) && Start;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    Busy     = 1'b0;
    Done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) state_nx = (Divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        Busy = 1'b1;
        if (last) state_nx = POST;
      end
      FIXUP: state_nx = DONE;
      DONE: begin
        Done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a     <= '0;
      q     <= '0;
      m     <= '0;
      count <= '0;
      quo   <= '0;
      rem   <= '0;
      dz    <= 1'b0;
`ifdef SEQ_DIVIDER8_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else if (accept) begin
      if (Divisor == '0) begin
        quo <= '1;
        rem <= Dividend;
        dz  <= 1'b1;
      end else begin
        a     <= '0;
        q     <= dd_mag;
        m     <= dv_mag;
        count <= '0;
        dz    <= 1'b0;
`ifdef SEQ_DIVIDER8_SIGNED_EN
        neg_q <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
        neg_r <= Dividend[WIDTH-1];
`endif
      end
    end else if (state == CALC) begin
      a     <= a_nx;
      q     <= q_nx;
      count <= count + 1'b1;
      if (last) begin
        quo <= q_nx;
        rem <= a_nx[WIDTH-1:0];
      end
    end
`ifdef SEQ_DIVIDER8_SIGNED_EN
    else if (state == FIXUP) begin
      if (neg_q) quo <= -quo;
      if (neg_r) rem <= -rem;
    end
`endif
  end

  assign Quotient  = quo;
  assign Remainder = rem;
  assign DivZero   = dz;

endmodule

// File: doc/seq_divider8.md
Name: seq_divider8

Overview:
- Sequential unsigned restoring divider; the inverse operation of the shift-add multiplier datapath.
- Produces one quotient bit per clock using a (WIDTH+1)-bit trial subtract.
- Sits beside the multiplier in the lab datapath.
- Driven by a start/done handshake from the control/IO wrapper (switches, hex displays).

Parameters:
- WIDTH, 8, operand width of dividend, divisor, quotient and remainder.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- Dividend  input  WIDTH  numerator; captured on accepting edge.
- Divisor  input  WIDTH  denominator; captured on accepting edge.
- Busy  output  1  high while an operation is in CALC.
- Done  output  1  one-cycle pulse when results become valid.
- Quotient  output  WIDTH  result; held until next accepted Start.
- Remainder  output  WIDTH  result; held until next accepted Start.
- DivZero  output  1  set with Done when Divisor was 0; held with results.

Behaviour:
- Clock and reset: one clock (Clk); reset is asynchronous and active-low (Reset_n).
- Reset (async, any state): state=IDLE, Busy=0, Done=0, Quotient=0, Remainder=0, DivZero=0, internal A/Q/M/count=0.
- Reset mid-operation aborts with no Done.
- States: IDLE, CALC, DONE.
- IDLE, Start=1 at edge k, Divisor!=0:
  - A<=0 (WIDTH+1 bits), Q<=Dividend, M<=Divisor, count<=0, DivZero<=0, go CALC.
- IDLE, Start=1 at edge k, Divisor==0:
  - Quotient<=all ones, Remainder<=Dividend, DivZero<=1, go DONE (Done high during cycle k+1).
- CALC, each edge:
  - {A,Q} shifted left one bit (Q MSB enters A LSB).
  - T = A_shifted - {1'b0,M} in WIDTH+1 bits.
  - If T sign bit = 0: A<=T, Q[0]<=1; else A unchanged (restore), Q[0]<=0.
  - count increments; after the WIDTH-th CALC edge (edge k+WIDTH), go DONE.
  - Quotient<=Q and Remainder<=A[WIDTH-1:0] are registered on that same edge.
- Busy=1 exactly in CALC, i.e. cycles k+1..k+WIDTH.
- DONE: Done=1 for exactly one cycle (k+WIDTH+1 normal, k+1 divide-by-zero); next edge returns to IDLE unconditionally.
- Latency: Start edge to Done = WIDTH+1 cycles (9 for default); divide-by-zero = 1 cycle.
- Start in CALC or DONE is ignored (no queueing). Held-high Start re-triggers only once back in IDLE.
- Quotient/Remainder/DivZero change only on an accepting edge path; stable otherwise.
- Invariant: Dividend = Quotient*Divisor + Remainder, Remainder < Divisor (unsigned, Divisor!=0).
- Operand inputs may change freely after the accepting edge.

Optional Feature:
- Macro: SEQ_DIVIDER8_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - On accept, magnitudes are loaded and the signs registered.
  - An extra FIXUP state after CALC negates Quotient if the signs differ, and negates Remainder if Dividend was negative (remainder takes dividend sign, truncating division).
  - Latency becomes WIDTH+2.
  - Divide-by-zero unchanged: Quotient all ones, Remainder=Dividend, 1-cycle.
- Undefined: unsigned only, no FIXUP state, latency WIDTH+1.

Decomposition:
- Shared package divider_pkg:
  - state enum type (IDLE, CALC, FIXUP, DONE).
  - localparam DIV_W=8.
  - localparam CNT_W=$clog2(DIV_W+1).
- Sub-module: div_trial_sub, combinational (WIDTH+1)-bit subtractor returning difference and sign; instantiated once inside the divider.

Test Plan:
- Dividend=100, Divisor=7, Start at edge k -> Busy cycles k+1..k+8; Done pulse at k+9; Quotient=14, Remainder=2, DivZero=0.
- Dividend=255, Divisor=1 -> Quotient=255, Remainder=0; Dividend=5, Divisor=9 -> Quotient=0, Remainder=5.
- Dividend=42, Divisor=0 -> Done at k+1, Quotient=0xFF, Remainder=42, DivZero=1; next normal op clears DivZero.
- Start re-pulsed and operands changed during CALC of 100/7 -> ignored; result still 14 R 2; Start held high -> second operation begins only after return to IDLE.
- Reset_n low mid-CALC (cycle k+4) -> outputs 0 immediately (async), no Done; fresh 200/13 afterwards -> Quotient=15, Remainder=5.
- With SEQ_DIVIDER8_SIGNED_EN: -100/7 -> Quotient=0xF2 (-14), Remainder=0xFE (-2), Done at k+10; 100/-7 -> Quotient=0xF2, Remainder=2.
